// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O block at 0xFFFF0000-0xFFFF000C:
// register word offsets, LFSR constants and the LFSR step function.
package io_pkg;

    typedef logic [1:0] io_offset_t;

    localparam io_offset_t IO_KEY   = 2'd0;
    localparam io_offset_t IO_MSCNT = 2'd1;
    localparam io_offset_t IO_RAND  = 2'd2;
    localparam io_offset_t IO_LED   = 2'd3;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam logic [31:0] RAND_SEED = 32'hACE1ACE1;

    // Right-shifting Galois LFSR: taps fold in whenever a one falls off the bottom.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/io_if.sv
// CPU-side load/store port of the I/O block; the decoder/control unit is master.
interface io_if;
    import io_pkg::*;

    logic        en;
    logic        memRead;
    logic        memWrite;
    logic [3:0]  physicalAddr;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport master (
        output en, memRead, memWrite, physicalAddr, writeData,
        input  readData
    );

    modport slave (
        input  en, memRead, memWrite, physicalAddr, writeData,
        output readData
    );

endinterface

// File: rtl/io_key_capture.sv
// Synchronises raw buttons, detects a press (nonzero after all-zero) and latches
// the key code with a valid flag that a read can clear.
module io_key_capture
    import io_pkg::*;
#(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keyIn,
    input  logic             clear,
    output logic [7:0]       code,
    output logic             valid
);

    logic [KEY_W-1:0] sync1_q, sync1_d;
    logic [KEY_W-1:0] sync2_q, sync2_d;
    logic [KEY_W-1:0] prev_q, prev_d;
    logic [7:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             press;

    // A press arriving in the same cycle as a clearing read takes priority.
    always_comb begin
        sync1_d = keyIn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        press   = (sync2_q != '0) && (prev_q == '0);
        code_d  = code_q;
        valid_d = valid_q;
        if (press) begin
            code_d  = 8'(sync2_q);
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O peripheral: key capture, millisecond counter, pseudo-random
// generator and LED register behind a zero-latency read mux.
module io_controller
    import io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int MS_TICKS    = CLK_FREQ_HZ / 1000,
    parameter int KEY_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    io_if.slave              bus,
    input  logic [KEY_W-1:0] keyIn,
    output logic [7:0]       leds,
    output logic             keyIrq
);

    localparam int                 PRESC_W   = $clog2(MS_TICKS);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(MS_TICKS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        mscnt_q, mscnt_d;
    logic [31:0]        rand_q, rand_d;
    logic [7:0]         leds_q, leds_d;

    logic       rd, wr, ms_tick, key_clear, key_valid;
    logic [7:0] key_code;
    io_offset_t offset;
    logic [31:0] read_data;
    logic        unused_addr_bits;

    assign rd               = bus.en & bus.memRead;
    assign wr               = bus.en & bus.memWrite;
    assign offset           = bus.physicalAddr[3:2];
    assign unused_addr_bits = ^bus.physicalAddr[1:0];
    assign key_clear        = rd && (offset == IO_KEY);

    io_key_capture #(.KEY_W(KEY_W)) u_key (
        .clk   (clk),
        .rst   (rst),
        .keyIn (keyIn),
        .clear (key_clear),
        .code  (key_code),
        .valid (key_valid)
    );

    // A store to MSCNT restarts the millisecond period and beats a coincident tick.
    always_comb begin
        ms_tick = (presc_q == PRESC_MAX);
        presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);
        mscnt_d = ms_tick ? mscnt_q + 32'd1 : mscnt_q;
        if (wr && (offset == IO_MSCNT)) begin
            mscnt_d = bus.writeData;
            presc_d = '0;
        end

        rand_d = lfsr_step(rand_q);
        if (wr && (offset == IO_RAND)) begin
            rand_d = (bus.writeData == 32'd0) ? 32'd1 : bus.writeData;
        end

        leds_d = leds_q;
        if (wr && (offset == IO_LED)) begin
            leds_d = bus.writeData[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            mscnt_q <= '0;
            rand_q  <= RAND_SEED;
            leds_q  <= '0;
        end else begin
            presc_q <= presc_d;
            mscnt_q <= mscnt_d;
            rand_q  <= rand_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        read_data = '0;
        if (rd) begin
            case (offset)
                IO_KEY:   read_data = {key_valid, 23'b0, key_code};
                IO_MSCNT: read_data = mscnt_q;
                IO_RAND:  read_data = rand_q;
                IO_LED:   read_data = {24'b0, leds_q};
                default:  read_data = '0;
            endcase
        end
    end

    assign bus.readData = read_data;
    assign leds         = leds_q;
    assign keyIrq       = key_valid;

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped I/O peripheral directly downstream of the CPU memory decoder.
- Selected when the decoder asserts memEnable[2], bank 2'b10, for virtual range 0xFFFF0000–0xFFFF000C.
- Provides four word registers: key capture, millisecond counter, pseudo-random generator, LED output.
- Read data returns through the memBank read mux.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- MS_TICKS, CLK_FREQ_HZ/1000, clock cycles per millisecond tick; must be ≥2.
- KEY_W, 8, width of raw key/button input.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  memEnable[2] from decoder.
- memRead  in  1  load strobe from control unit.
- memWrite  in  1  store strobe from control unit.
- physicalAddr  in  4  decoder physicalAddr[3:0]; word offset = [3:2], [1:0] ignored.
- writeData  in  32  store data.
- keyIn  in  KEY_W  raw asynchronous buttons, active-high.
- readData  out  32  register read value.
- leds  out  8  LED register.
- keyIrq  out  1  copy of key-valid flag.

Behaviour:
- Access: rd = en & memRead; wr = en & memWrite. Both may be high together; both are honoured.
- Register map (offset[3:2]):
  - 0 KEY: {valid, 23'b0, code[7:0]}
  - 1 MSCNT
  - 2 RAND
  - 3 LED: {24'b0, leds}
- readData is combinational from current register state and offset; 0-cycle latency. When rd=0, readData=0.
- All read side effects and writes take effect at the clock edge ending the access cycle.
- Reset (rst=0, async): valid=0, code=0, MSCNT=0, prescaler=0, RAND=32'hACE1ACE1, leds=0, sync/edge flops=0. Hence readData=0 and keyIrq=0.
- KEY capture:
  - keyIn passes a 2-flop synchronizer, then a registered previous copy.
  - Press event: synced value ≠0 while previous value =0.
  - On press: code ← synced value zero-extended, valid ← 1.
  - rd at offset 0 clears valid at the edge; code is retained.
  - Press and clearing read in the same cycle: press wins (valid stays 1, new code).
  - Writes to offset 0 are ignored.
  - Press-to-visible latency: 3 clocks.
- MSCNT:
  - Prescaler counts 0..MS_TICKS-1 and wraps. On wrap, MSCNT increments.
  - MSCNT wraps 0xFFFFFFFF→0.
  - wr at offset 1: MSCNT ← writeData, prescaler ← 0. This overrides a coincident tick.
- RAND:
  - 32-bit Galois LFSR, right shift, taps 32'h80200003. Advances every clock.
  - Step: next = lsb ? (s>>1) ^ taps : s>>1.
  - wr at offset 2 loads writeData (no advance that cycle); writeData=0 loads 1 instead.
  - rd has no side effect.
- LED: wr at offset 3 sets leds ← writeData[7:0]; upper bits discarded.
- en=0: strobes are ignored; background counters and capture keep running.
- Reset mid-access: all state returns to reset values immediately; the pending write is lost.

Decomposition:
- Shared package io_pkg holds:
  - offset constants IO_KEY=2'd0, IO_MSCNT=2'd1, IO_RAND=2'd2, IO_LED=2'd3
  - LFSR_TAPS=32'h80200003
  - RAND_SEED=32'hACE1ACE1
- Sub-module io_key_capture contains synchronizer, edge detect, and code/valid latch, with clear input.
- Counter, LFSR, LED register and read mux are in the top.

Test Plan:
- Reset: rst low mid-run → readData=0, leds=0, keyIrq=0 asynchronously. A read of offset 2 immediately after release returns 32'hACE1ACE1.
- Key capture: keyIn 0→8'h35 held → after 3 clks keyIrq=1 and read offset 0 = 32'h80000035. Next read = 32'h00000035. Release then press 8'h04 in the same cycle as a clearing read → valid stays 1, code 0x04.
- Millisecond counter (MS_TICKS=4):
  - Write 0xFFFFFFFE to offset 1 → 4 clks later read 0xFFFFFFFF; 8 clks later read 0x00000000.
  - Write coincident with a tick → written value held for a full 4 clks.
- LFSR: write 0 to offset 2 → next-cycle read = 1, following cycle = 32'h80200003. Write 32'h2 → next cycle reads 2, then 1.
- LEDs and enable gating:
  - Write 32'hFFFFFFA5 to offset 3 → leds=8'hA5, read 0x000000A5.
  - Same write with en=0 → leds unchanged, readData=0.
- Simultaneous memRead & memWrite at offset 1 → readData shows the old value; the new value is visible next cycle.
